// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: one memory op at a time over a req/ack data bus,
// with byte-lane selection, pipeline stall, local misalign/timeout abort.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        start,
  input  logic [5:0]  cuOP,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  input  logic        busAck,
  input  logic [31:0] busRdata,
  output logic        busRen,
  output logic        busWen,
  output logic [31:0] busAddr,
  output logic [31:0] busWdata,
  output logic [3:0]  busSel,
  output logic [31:0] memload,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [1:0]  dbg_state
);

  // Handshake: start is "valid" and ~stall is "ready"; an op is taken only in
  // IDLE. On the bus, busRen/busWen is the request and busAck completes it;
  // exactly one transfer is outstanding and requests stay stable until ack.

  localparam logic [5:0] OP_LB  = 6'd10;
  localparam logic [5:0] OP_LH  = 6'd11;
  localparam logic [5:0] OP_LW  = 6'd12;
  localparam logic [5:0] OP_LBU = 6'd13;
  localparam logic [5:0] OP_LHU = 6'd14;
  localparam logic [5:0] OP_SB  = 6'd15;
  localparam logic [5:0] OP_SH  = 6'd16;
  localparam logic [5:0] OP_SW  = 6'd17;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic op_is_mem(input logic [5:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

  function automatic logic op_is_load(input logic [5:0] op);
    return (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  // 0 = byte, 1 = half, 2 = word
  function automatic logic [1:0] op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 2'd0;
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      default:              return 2'd2;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic        err_q, err_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic [31:0] baddr_q, baddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] memload_q, memload_d;

  logic        in_mem;
  logic        in_load;
  logic [1:0]  in_size;
  logic        in_misaligned;
  logic [31:0] rd_shifted;

  always_comb begin
    in_mem        = op_is_mem(cuOP);
    in_load       = op_is_load(cuOP);
    in_size       = op_size(cuOP);
    in_misaligned = ((in_size == 2'd1) && addr[0]) ||
                    ((in_size == 2'd2) && (addr[1:0] != 2'b00));
    rd_shifted    = busRdata >> {off_q, 3'b000};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    off_d     = off_q;
    err_d     = err_q;
    ren_d     = ren_q;
    wen_d     = wen_q;
    baddr_d   = baddr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    memload_d = memload_q;

    case (state_q)
      S_IDLE: begin
        if (start && in_mem) begin
          op_d  = cuOP;
          off_d = addr[1:0];
          cnt_d = 16'd0;
          if (in_misaligned) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_BUS;
            ren_d   = in_load;
            wen_d   = ~in_load;
            baddr_d = {addr[31:2], 2'b00};
            case (in_size)
              2'd0: begin
                sel_d   = 4'b0001 << addr[1:0];
                wdata_d = {4{storeData[7:0]}};
              end
              2'd1: begin
                sel_d   = 4'b0011 << addr[1:0];
                wdata_d = {2{storeData[15:0]}};
              end
              default: begin
                sel_d   = 4'b1111;
                wdata_d = storeData;
              end
            endcase
          end
        end
      end

      S_BUS: begin
        // An ack on the final allowed cycle still completes normally.
        if (busAck) begin
          if (op_is_load(op_q)) begin
            case (op_size(op_q))
              2'd0:    memload_d = {24'd0, rd_shifted[7:0]};
              2'd1:    memload_d = {16'd0, rd_shifted[15:0]};
              default: memload_d = rd_shifted;
            endcase
          end
          err_d   = 1'b0;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          cnt_d   = 16'd0;
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          cnt_d   = 16'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      op_q      <= 6'd0;
      off_q     <= 2'd0;
      err_q     <= 1'b0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      baddr_q   <= 32'd0;
      wdata_q   <= 32'd0;
      sel_q     <= 4'd0;
      memload_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      off_q     <= off_d;
      err_q     <= err_d;
      ren_q     <= ren_d;
      wen_q     <= wen_d;
      baddr_q   <= baddr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      memload_q <= memload_d;
    end
  end

  always_comb begin
    busRen    = ren_q;
    busWen    = wen_q;
    busAddr   = baddr_q;
    busWdata  = wdata_q;
    busSel    = sel_q;
    memload   = memload_q;
    done      = (state_q == S_DONE);
    err       = (state_q == S_DONE) && err_q;
    stall     = (state_q == S_BUS) || ((state_q == S_IDLE) && start && in_mem);
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed ops from the test plan plus a random
// mix, checked per cycle and through an expected-result queue on done.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  localparam logic [5:0] OP_LB  = 6'd10;
  localparam logic [5:0] OP_LH  = 6'd11;
  localparam logic [5:0] OP_LW  = 6'd12;
  localparam logic [5:0] OP_LBU = 6'd13;
  localparam logic [5:0] OP_LHU = 6'd14;
  localparam logic [5:0] OP_SB  = 6'd15;
  localparam logic [5:0] OP_SH  = 6'd16;
  localparam logic [5:0] OP_SW  = 6'd17;
  localparam logic [5:0] OP_ADD = 6'd28;

  logic        clk;
  logic        nRst;
  logic        start;
  logic [5:0]  cuOP;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic        busAck;
  logic [31:0] busRdata;
  logic        busRen;
  logic        busWen;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [3:0]  busSel;
  logic [31:0] memload;
  logic        stall;
  logic        done;
  logic        err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] exp_q[$];   // {err, memload}
  logic [31:0] model_memload = 32'd0;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .nRst(nRst), .start(start), .cuOP(cuOP), .addr(addr),
    .storeData(storeData), .busAck(busAck), .busRdata(busRdata),
    .busRen(busRen), .busWen(busWen), .busAddr(busAddr), .busWdata(busWdata),
    .busSel(busSel), .memload(memload), .stall(stall), .done(done), .err(err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] size_of(input logic [5:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 2'd0;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * a[1:0]);
    case (size_of(op))
      2'd0:    return sh & 32'h0000_00FF;
      2'd1:    return sh & 32'h0000_FFFF;
      default: return sh;
    endcase
  endfunction

  // scoreboard: every done pulse pops one expected {err, memload}
  always @(negedge clk) begin
    if (nRst) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("done_spurious", 32'(done), 32'd0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("sb_err", 32'(err), 32'(e[32]));
          check("sb_memload", memload, e[31:0]);
        end
      end else if (err) begin
        check("err_without_done", 32'(err), 32'd0);
      end
    end
  end

  // driver: ack_at = bus cycle (0-based) carrying busAck, or -1 for no ack
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                        input int ack_at, input logic [31:0] rd);
    logic       mem, ld, mis;
    logic [1:0] sz;
    logic [3:0] sel;
    logic [31:0] wd;
    int         bus_cycles;
    mem = (op >= OP_LB) && (op <= OP_SW);
    ld  = (op >= OP_LB) && (op <= OP_LHU);
    sz  = size_of(op);
    mis = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    case (sz)
      2'd0:    begin sel = 4'b0001 << a[1:0]; wd = {4{sd[7:0]}}; end
      2'd1:    begin sel = 4'b0011 << a[1:0]; wd = {2{sd[15:0]}}; end
      default: begin sel = 4'b1111;           wd = sd;           end
    endcase

    @(negedge clk);
    start = 1'b1; cuOP = op; addr = a; storeData = sd;
    busAck = 1'($urandom_range(0, 1)); busRdata = $urandom;
    #1 check("stall_c0", 32'(stall), 32'(mem));
    if (mem) begin
      if (!mis && ld && ack_at >= 0) model_memload = exp_load(op, a, rd);
      exp_q.push_back({(mis || ack_at < 0), model_memload});
    end

    @(negedge clk);
    start = 1'b0; cuOP = 6'd0; addr = $urandom; storeData = $urandom;
    if (!mem || mis) begin
      check("nobus_ren", 32'(busRen), 32'd0);
      check("nobus_wen", 32'(busWen), 32'd0);
      check("nobus_stall", 32'(stall), 32'd0);
      check("nobus_done", 32'(done), 32'(mem));
      busAck = 1'b0;
      return;
    end

    bus_cycles = (ack_at < 0) ? TO : ack_at + 1;
    for (int i = 0; i < bus_cycles; i++) begin
      check("bus_ren", 32'(busRen), 32'(ld));
      check("bus_wen", 32'(busWen), 32'(!ld));
      check("bus_addr", busAddr, {a[31:2], 2'b00});
      check("bus_sel", 32'(busSel), 32'(sel));
      if (!ld) check("bus_wdata", busWdata, wd);
      check("bus_stall", 32'(stall), 32'd1);
      check("bus_done", 32'(done), 32'd0);
      busAck   = (i == ack_at);
      busRdata = (i == ack_at) ? rd : $urandom;
      @(negedge clk);
    end
    busAck = 1'($urandom_range(0, 1));
    busRdata = $urandom;
    check("done_at", 32'(done), 32'd1);
    check("done_ren", 32'(busRen), 32'd0);
    check("done_wen", 32'(busWen), 32'd0);
    check("done_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    nRst = 1'b0; start = 1'b0; cuOP = 6'd0; addr = 32'd0; storeData = 32'd0;
    busAck = 1'b0; busRdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_ren", 32'(busRen), 32'd0);
    check("rst_wen", 32'(busWen), 32'd0);
    check("rst_addr", busAddr, 32'd0);
    check("rst_wdata", busWdata, 32'd0);
    check("rst_sel", 32'(busSel), 32'd0);
    check("rst_memload", memload, 32'd0);
    check("rst_done", 32'(done | err | stall), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    nRst = 1'b1;

    // directed cases from the test plan
    run_op(OP_LW,  32'h0000_0100, 32'h0,          2,  32'hDEAD_BEEF);
    run_op(OP_LB,  32'h0000_0203, 32'h0,          0,  32'h8011_2233);
    run_op(OP_SH,  32'h0000_000A, 32'h1234_ABCD,  0,  32'h0);
    run_op(OP_LW,  32'h0000_0102, 32'h0,          0,  32'h0);
    run_op(OP_LHU, 32'h0000_0040, 32'h0,          -1, 32'h0);
    run_op(OP_LW,  32'h0000_0044, 32'h0,          0,  32'h0BAD_F00D);
    run_op(OP_ADD, 32'h0000_0050, 32'h0,          0,  32'h0);
    run_op(OP_LBU, 32'h0000_0061, 32'h0,          TO - 1, 32'hA1B2_C3D4);
    run_op(OP_SB,  32'h0000_0072, 32'h0000_005A,  1,  32'h0);
    run_op(OP_SW,  32'h0000_0080, 32'hFEED_FACE,  -1, 32'h0);

    // asynchronous reset in the middle of a store
    @(negedge clk);
    start = 1'b1; cuOP = OP_SW; addr = 32'h0000_0300; storeData = 32'hCAFE_F00D;
    busAck = 1'b0;
    @(negedge clk);
    start = 1'b0; cuOP = 6'd0;
    check("rstmid_wen_pre", 32'(busWen), 32'd1);
    #2 nRst = 1'b0;
    #1;
    check("rstmid_wen", 32'(busWen), 32'd0);
    check("rstmid_ren", 32'(busRen), 32'd0);
    check("rstmid_addr", busAddr, 32'd0);
    check("rstmid_wdata", busWdata, 32'd0);
    check("rstmid_sel", 32'(busSel), 32'd0);
    check("rstmid_memload", memload, 32'd0);
    check("rstmid_flags", 32'(done | err | stall), 32'd0);
    model_memload = 32'd0;
    @(negedge clk);
    nRst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rstmid_no_done", 32'(done), 32'd0);
    end
    run_op(OP_LH, 32'h0000_0002, 32'h0, 0, 32'hBEEF_1234);

    // random mix
    for (int n = 0; n < 30; n++) begin
      logic [5:0]  op;
      logic [31:0] a;
      logic [1:0]  sz;
      op = 6'($urandom_range(10, 17));
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(18, 63));
      a  = $urandom;
      sz = size_of(op);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      run_op(op, a, $urandom, $urandom_range(0, TO) - 1, $urandom);
    end

    repeat (2) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store sequencer between the decode/execute stage and the data-memory bus. Accepts one memory operation (by `cuOP` code) with address and store data, drives a single-outstanding request/acknowledge bus transaction with byte-lane selection, stalls the pipeline until completion, and returns the addressed bytes right-justified on `memload`. Sign/zero extension of `memload` stays in the writeback mux. Misaligned accesses and bus timeouts are terminated locally with an error pulse.

## Interface
- `TIMEOUT`, 64: bus cycles without `busAck` before abort; legal range 2–65535.
- `clk` in 1: clock, rising edge.
- `nRst` in 1: asynchronous active-low reset.
- `start` in 1: operation valid this cycle; sampled only in IDLE.
- `cuOP` in 6: op code, same enum encoding as the control unit: LB=10, LH=11, LW=12, LBU=13, LHU=14, SB=15, SH=16, SW=17; any other value is a non-memory op.
- `addr` in 32: byte address (ALU result).
- `storeData` in 32: rs2 value.
- `busAck` in 1: memory completes the current transfer this cycle.
- `busRdata` in 32: read word, valid when `busAck`=1.
- `busRen` out 1: read request.
- `busWen` out 1: write request.
- `busAddr` out 32: word address, `{addr[31:2],2'b00}`.
- `busWdata` out 32: lane-replicated store data.
- `busSel` out 4: byte-lane enables.
- `memload` out 32: right-justified, zero-filled load data.
- `stall` out 1: hold pipeline.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle error pulse, coincident with `done`.

## Operation
- States: IDLE, BUS, DONE.
- IDLE: `start`=1 with memory `cuOP` latches `cuOP`, `addr`, `storeData`.
  - Aligned op → BUS.
  - Misaligned op → DONE with error flag. Misaligned means LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0.
  - Non-memory `cuOP` or `start`=0: stay in IDLE, no outputs.
- BUS: request outputs are driven from the latched copy.
  - `busRen`=1 for loads; `busWen`=1 for stores; never both.
  - `busAck`=1 → capture `busRdata` (loads only), then go to DONE.
  - Timeout counter reaches `TIMEOUT` without ack → DONE with error flag.
- DONE: `done`=1; `err`=error flag; then IDLE unconditionally.
- Lane select:
  - Byte ops: `busSel`=`4'b0001<<addr[1:0]`.
  - Half ops: `4'b0011<<addr[1:0]`.
  - Word ops: `4'b1111`.
- Store data:
  - SB: `{4{storeData[7:0]}}`.
  - SH: `{2{storeData[15:0]}}`.
  - SW: `storeData`.
- `memload` = captured word `>>` (8·`addr[1:0]`), upper bits zero, then masked to the access width (8/16/32 bits).
  - Holds its value until the next load capture.
  - Stores, errors and timeouts leave it unchanged.
- `stall` (combinational):
  - 1 in IDLE when `start`=1 with a memory `cuOP`.
  - 1 throughout BUS.
  - 0 in DONE and otherwise.
- While in BUS or DONE, `start` is ignored; the upstream stage holds its op under `stall`.

## Timing
- Reset: IDLE, timeout counter 0. All outputs 0, including `memload`, `busAddr`, `busWdata` and `busSel`.
- Reset takes effect asynchronously, mid-transaction included. Bus requests drop immediately, no `done` is produced, and the op is lost.
- Aligned op, ack on first bus cycle:
  - Cycle 0: `start`.
  - Cycle 1: BUS, request high, `busAck`=1.
  - Cycle 2: `done`=1, `memload` valid.
  - Latency 2 cycles; each wait cycle adds 1.
- Misaligned op: `start` in cycle 0; `done`=`err`=1 in cycle 1. No bus request is asserted.
- Timeout: request held for exactly `TIMEOUT` cycles. `done`/`err` in the next cycle. Request is low in the DONE cycle.
- `busAck` outside BUS is ignored.
- Back-to-back ops: a new `start` is accepted in the cycle after DONE, giving a minimum 3-cycle issue interval.
- Request outputs are registered and stable for the whole BUS interval.

## Test plan
- LW, `addr`=0x100, ack after 2 wait cycles → `busRen`=1 for 3 cycles, `busSel`=1111, `busAddr`=0x100; `busRdata`=0xDEADBEEF → `memload`=0xDEADBEEF, `done` 4 cycles after `start`, `stall` high for cycles 0–3.
- LB, `addr`=0x203, `busRdata`=0x80112233, immediate ack → `busSel`=1000, `busAddr`=0x200, `memload`=0x00000080.
- SH, `addr`=0x0A, `storeData`=0x1234ABCD → `busWen`=1, `busSel`=1100, `busWdata`=0xABCDABCD, `busRen`=0, `memload` unchanged.
- LW, `addr`=0x102 → no bus request; `done`=`err`=1 in cycle 1; `stall` high in cycle 0 only.
- LHU, `addr`=0x40, `TIMEOUT`=4, no ack → `busRen` high for exactly 4 cycles, then `done`=`err`=1, then IDLE. A following LW with immediate ack completes normally.
- Assert `nRst` low during BUS of an SW → all outputs 0 immediately, no `done`. Also check that `cuOP`=ADD (28) with `start`=1 gives no `stall` and no bus activity.
